// File: rtl/instruction_prefetch_queue.sv
// Instruction prefetch queue: issues sequential fetches to a multi-cycle
// instruction memory over a req/ack handshake, buffers up to DEPTH
// {PC, instruction} pairs and presents the oldest one to decode.
// A taken branch (Redirect) flushes the queue and restarts fetch; a request
// already in flight is allowed to complete and its data is dropped.
// Optional build macro: IPQ_PERF_CNT_EN adds the FetchCnt/DiscardCnt counters.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_BOOT    | first cycle after reset; captures StartPC as the fetch PC
// ST_FETCH   | normal operation; requests issued while the queue has room
// ST_DISCARD | redirected with a request in flight; waits for its ack and
//            | drops the returning data, then refetches at the new PC
module instruction_prefetch_queue #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic [ADDR_W-1:0]  StartPC,
  input  logic               Redirect,
  input  logic [ADDR_W-1:0]  RedirectPC,
  output logic               IMemReq,
  output logic [ADDR_W-1:0]  IMemAddr,
  input  logic               IMemAck,
  input  logic [INSTR_W-1:0] IMemData,
  output logic               InstrValid,
  output logic [INSTR_W-1:0] Instr,
  output logic [ADDR_W-1:0]  InstrPC,
  input  logic               Stall
`ifdef IPQ_PERF_CNT_EN
  ,
  output logic [31:0]        FetchCnt,
  output logic [31:0]        DiscardCnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_FETCH,
    ST_DISCARD
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d, next_pc;
  logic               req_q, req_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               push, pop, ack;
  logic [ADDR_W-1:0]  start_tgt, redirect_tgt;

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];

  // Word-align both restart addresses by clearing the low two bits.
  assign start_tgt    = StartPC & ~ADDR_W'(3);
  assign redirect_tgt = RedirectPC & ~ADDR_W'(3);
  assign ack          = req_q & IMemAck;

  // Next-state, fetch-issue and queue-pointer logic.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    next_pc    = pc_q;
    push       = 1'b0;
    pop        = 1'b0;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
        next_pc = Redirect ? redirect_tgt : start_tgt;
      end
      ST_FETCH: begin
        if (Redirect) begin
          next_pc = redirect_tgt;
          // An ack in the redirect cycle closes the request; its data is dropped.
          if (req_q && !IMemAck) state_d = ST_DISCARD;
          else                   req_d   = 1'b0;
        end else begin
          if (ack) begin
            push    = 1'b1;
            next_pc = addr_q + ADDR_W'(4);
            req_d   = 1'b0;
          end
          pop = (count_q != '0) && !Stall;
        end
      end
      ST_DISCARD: begin
        if (Redirect) next_pc = redirect_tgt;
        if (ack) begin
          req_d   = 1'b0;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_BOOT;
    endcase
    pc_d = next_pc;

    if (Redirect) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      head_d  = head_q + PTR_W'(pop);
      tail_d  = tail_q + PTR_W'(push);
    end

    // New request only once nothing is in flight and the queue has a free slot,
    // which also guarantees an ack can never arrive with the queue full.
    if (state_d == ST_FETCH && !req_d && count_d < DEPTH_C) begin
      req_d  = 1'b1;
      addr_d = next_pc;
    end

    // Head registers follow the new head entry; when empty they hold.
    if (count_d != '0) begin
      if (push && head_d == tail_q) begin
        instr_d    = IMemData;
        instr_pc_d = addr_q;
      end else begin
        instr_d    = instr_mem[head_d];
        instr_pc_d = pc_mem[head_d];
      end
    end
  end

  // State, fetch and queue-control registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  // Queue storage; contents are only meaningful between head and tail.
  always_ff @(posedge Clk) begin
    if (push) begin
      instr_mem[tail_q] <= IMemData;
      pc_mem[tail_q]    <= addr_q;
    end
  end

  assign IMemReq    = req_q;
  assign IMemAddr   = addr_q;
  assign InstrValid = (count_q != '0);
  assign Instr      = instr_q;
  assign InstrPC    = instr_pc_q;

`ifdef IPQ_PERF_CNT_EN
  logic drop_ack;
  assign drop_ack = ack && (state_q == ST_DISCARD || (state_q == ST_FETCH && Redirect));

  // Accepted-fetch and discarded-instruction counters, free-running modulo 2^32.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      FetchCnt   <= '0;
      DiscardCnt <= '0;
    end else begin
      if (push) FetchCnt <= FetchCnt + 32'd1;
      DiscardCnt <= DiscardCnt + (Redirect ? 32'(count_q) : 32'd0) + {31'd0, drop_ack};
    end
  end
`endif

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Bench for instruction_prefetch_queue: directed scenarios followed by a
// randomized phase, all checked against a transaction-level queue model.
module tb_instruction_prefetch_queue;

  localparam int DEPTH = 4;

  logic        Clk, Rst_n;
  logic [63:0] StartPC, RedirectPC, IMemAddr, InstrPC;
  logic        Redirect, IMemReq, IMemAck, InstrValid, Stall;
  logic [31:0] IMemData, Instr;
`ifdef IPQ_PERF_CNT_EN
  logic [31:0] FetchCnt, DiscardCnt;
`endif

  instruction_prefetch_queue #(.DEPTH(DEPTH), .ADDR_W(64), .INSTR_W(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .StartPC(StartPC), .Redirect(Redirect),
    .RedirectPC(RedirectPC), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemAck(IMemAck), .IMemData(IMemData), .InstrValid(InstrValid),
    .Instr(Instr), .InstrPC(InstrPC), .Stall(Stall)
`ifdef IPQ_PERF_CNT_EN
    , .FetchCnt(FetchCnt), .DiscardCnt(DiscardCnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [63:0] exp_q[$];
  logic [63:0] exp_fetch, drop_addr;
  bit          drop_pend;
  int          idle, req_age, acc_cnt;
  logic [31:0] exp_fcnt, exp_dcnt;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h9E37_79B9;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, drive inputs, advance model.
  task automatic step(input bit ack_en, input bit stall, input bit redir, input logic [63:0] tgt);
    bit a, pop;
    chk("instr_valid", InstrValid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("instr_pc", InstrPC, exp_q[0]);
      chk("instr", Instr, instr_of(exp_q[0]));
    end
    if (IMemReq) begin
      chk("imem_addr", IMemAddr, drop_pend ? drop_addr : exp_fetch);
      chk("req_room", exp_q.size() < DEPTH, 1);
    end
    if (!IMemReq && exp_q.size() < DEPTH && !drop_pend) idle++;
    else idle = 0;
    chk("req_liveness", idle <= 3, 1);
`ifdef IPQ_PERF_CNT_EN
    chk("fetch_cnt", FetchCnt, exp_fcnt);
    chk("discard_cnt", DiscardCnt, exp_dcnt);
`endif
    a = ack_en && IMemReq;
    IMemAck    = a;
    IMemData   = a ? instr_of(IMemAddr) : $urandom;
    Stall      = stall;
    Redirect   = redir;
    RedirectPC = tgt;
    req_age = (IMemReq && !a) ? req_age + 1 : 0;

    pop = (exp_q.size() != 0) && !stall;
    if (redir) begin
      exp_dcnt += 32'(exp_q.size());
      exp_q.delete();
      if (drop_pend) begin
        if (a) begin drop_pend = 0; exp_dcnt++; end
      end else if (IMemReq) begin
        if (a) exp_dcnt++;
        else begin drop_pend = 1; drop_addr = exp_fetch; end
      end
      exp_fetch = tgt & ~64'h3;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (a) begin
        if (drop_pend) begin
          drop_pend = 0;
          exp_dcnt++;
        end else begin
          exp_q.push_back(exp_fetch);
          exp_fetch += 64'd4;
          exp_fcnt++;
          acc_cnt++;
        end
      end
    end
    @(negedge Clk);
  endtask

  task automatic do_reset(input logic [63:0] start);
    Rst_n = 1'b0; IMemAck = 1'b0; Stall = 1'b0; Redirect = 1'b0;
    RedirectPC = '0; IMemData = '0; StartPC = start;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    exp_q.delete();
    exp_fetch = start & ~64'h3;
    drop_pend = 0; drop_addr = '0;
    idle = 0; req_age = 0; acc_cnt = 0;
    exp_fcnt = '0; exp_dcnt = '0;
  endtask

  task automatic wait_req(input bit stall);
    for (int i = 0; i < 20 && !IMemReq; i++) step(0, stall, 0, '0);
    chk("req_timeout", IMemReq, 1);
  endtask

  initial begin
    Rst_n = 1'b1; StartPC = 64'h100; Redirect = 1'b0; RedirectPC = '0;
    IMemAck = 1'b0; IMemData = '0; Stall = 1'b0;
    #3 Rst_n = 1'b0;
    #1;
    chk("rst_req", IMemReq, 0);
    chk("rst_addr", IMemAddr, 0);
    chk("rst_valid", InstrValid, 0);
    chk("rst_instr", Instr, 0);
    chk("rst_pc", InstrPC, 0);
    @(negedge Clk);

    // 1: sequential fetch, ack one cycle after each request
    do_reset(64'h100);
    wait_req(0);
    chk("t1_first_addr", IMemAddr, 64'h100);
    for (int i = 0; i < 16; i++) step(req_age >= 1, 0, 0, '0);

    // 2: decode stalled fills the queue
    do_reset(64'h100);
    for (int i = 0; i < 25; i++) step(req_age >= 1, 1, 0, '0);
    chk("t2_accepted", acc_cnt, 4);
    chk("t2_req_low", IMemReq, 0);
    chk("t2_head_pc", InstrPC, 64'h100);
    for (int i = 0; i < 14; i++) step(req_age >= 1, 0, 0, '0);

    // 3: redirect while 0x10C outstanding
    do_reset(64'h100);
    for (int i = 0; i < 40 && !(IMemReq && IMemAddr == 64'h10C); i++) step(req_age >= 1, 1, 0, '0);
    chk("t3_reached", IMemReq && IMemAddr == 64'h10C, 1);
    step(0, 1, 1, 64'h203);
    step(0, 1, 0, '0);
    chk("t3_held", IMemAddr, 64'h10C);
    step(0, 1, 0, '0);
    step(1, 1, 0, '0);
    chk("t3_new_req", IMemReq, 1);
    chk("t3_new_addr", IMemAddr, 64'h200);
    for (int i = 0; i < 12; i++) step(req_age >= 1, 0, 0, '0);

    // 4: redirect coincident with ack
    do_reset(64'h100);
    wait_req(0);
    step(1, 0, 1, 64'h203);
    chk("t4_req", IMemReq, 1);
    chk("t4_addr", IMemAddr, 64'h200);
    chk("t4_valid", InstrValid, 0);
    for (int i = 0; i < 8; i++) step(req_age >= 1, 0, 0, '0);

    // 5: fetch address wraps
    do_reset(64'hFFFF_FFFF_FFFF_FFFC);
    wait_req(0);
    chk("t5_first_addr", IMemAddr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1, 0, 0, '0);
    wait_req(0);
    chk("t5_wrap_addr", IMemAddr, 64'h0);
    for (int i = 0; i < 6; i++) step(req_age >= 1, 0, 0, '0);

    // 6: asynchronous reset with 3 entries queued and a request in flight
    do_reset(64'h100);
    for (int i = 0; i < 40 && !(exp_q.size() == 3 && IMemReq); i++) step(req_age >= 1, 1, 0, '0);
    chk("t6_reached", exp_q.size() == 3 && IMemReq, 1);
    #2 Rst_n = 1'b0;
    #1;
    chk("t6_req", IMemReq, 0);
    chk("t6_valid", InstrValid, 0);
    chk("t6_instr", Instr, 0);
    chk("t6_pc", InstrPC, 0);
`ifdef IPQ_PERF_CNT_EN
    chk("t6_fcnt", FetchCnt, 0);
    chk("t6_dcnt", DiscardCnt, 0);
`endif
    @(negedge Clk);
    do_reset(64'h100);
    wait_req(0);
    chk("t6_restart", IMemAddr, 64'h100);
    for (int i = 0; i < 6; i++) step(req_age >= 1, 0, 0, '0);

    // Randomized traffic: ack delays, stalls and redirects
    do_reset({$urandom, $urandom});
    for (int i = 0; i < 800; i++)
      step(($urandom % 2) == 0, ($urandom % 3) == 0, ($urandom % 16) == 0, {$urandom, $urandom});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
